// File: rtl/squeeze_stream_serializer_pkg.sv
// Shared types and widths for the squeeze stream serializer.
package squeeze_stream_serializer_pkg;

  localparam int SQ_WORD_W = 96;
  localparam int SQ_BEAT_W = 48;
  localparam int SQ_CNT_W  = 12;
  localparam int SQ_CFG_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_3X3 = 2'd1,
    ST_RD_1X1 = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/squeeze_stream_serializer_beat_splitter.sv
// Holds one popped FIFO word and presents it as two valid/ready beats, low half first.
module squeeze_beat_splitter
  import squeeze_stream_serializer_pkg::*;
#(
  parameter int WORD_W = SQ_WORD_W,
  parameter int BEAT_W = SQ_BEAT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              load_tag_i,
  input  logic              beat_ready_i,
  output logic              can_load_o,
  output logic              hold_empty_o,
  output logic [BEAT_W-1:0] beat_data_o,
  output logic              beat_valid_o,
  output logic              pixel_last_o
);

  logic [WORD_W-1:0] hold_q, hold_d;
  logic              half_q, half_d;
  logic              full_q, full_d;
  logic              tag_q, tag_d;
  logic              beat_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q <= '0;
      half_q <= 1'b0;
      full_q <= 1'b0;
      tag_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      half_q <= half_d;
      full_q <= full_d;
      tag_q  <= tag_d;
    end
  end

  // A new word may replace the current one in the same cycle its high half is accepted.
  assign beat_fire  = full_q & beat_ready_i;
  assign can_load_o = ~full_q | (beat_fire & half_q);

  always_comb begin
    hold_d = hold_q;
    half_d = half_q;
    full_d = full_q;
    tag_d  = tag_q;
    if (beat_fire) begin
      if (half_q) begin
        full_d = 1'b0;
        half_d = 1'b0;
      end else begin
        half_d = 1'b1;
      end
    end
    if (load_i) begin
      hold_d = load_data_i;
      full_d = 1'b1;
      half_d = 1'b0;
      tag_d  = load_tag_i;
    end
  end

  assign hold_empty_o = ~full_q;
  assign beat_valid_o = full_q;
  assign beat_data_o  = half_q ? hold_q[WORD_W-1:BEAT_W] : hold_q[BEAT_W-1:0];
  assign pixel_last_o = full_q & half_q & tag_q;

endmodule

// File: rtl/squeeze_stream_serializer.sv
// Drains the squeeze 3x3 and 1x1 FWFT FIFOs in fire concat order into one 48-bit beat stream.
module squeeze_stream_serializer
  import squeeze_stream_serializer_pkg::*;
#(
  parameter int WORD_W = SQ_WORD_W,
  parameter int BEAT_W = SQ_BEAT_W,
  parameter int CNT_W  = SQ_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [SQ_CFG_W-1:0] words_3x3_i,
  input  logic [SQ_CFG_W-1:0] words_1x1_i,
  input  logic [CNT_W-1:0]    layer_pixels_i,
  input  logic [WORD_W-1:0]   fifo_sq_3x3_rd_data_i,
  output logic                fifo_sq_3x3_rd_en_o,
  input  logic                fifo_sq_3x3_empty_i,
  input  logic [WORD_W-1:0]   fifo_sq_1x1_rd_data_i,
  output logic                fifo_sq_1x1_rd_en_o,
  input  logic                fifo_sq_1x1_empty_i,
  output logic [BEAT_W-1:0]   beat_data_o,
  output logic                beat_valid_o,
  input  logic                beat_ready_i,
  output logic                pixel_last_o,
  output logic                layer_done_o,
  output logic                busy_o
);

  state_e                state_q, state_d;
  logic [SQ_CFG_W-1:0]   word_cnt_q, word_cnt_d;
  logic [SQ_CFG_W-1:0]   w3_q, w3_d;
  logic [SQ_CFG_W-1:0]   w1_q, w1_d;
  logic [CNT_W-1:0]      pixel_cnt_q, pixel_cnt_d;
  logic [CNT_W-1:0]      pix_q, pix_d;

  logic                  can_load;
  logic                  hold_empty;
  logic                  pop_3x3;
  logic                  pop_1x1;
  logic                  load_tag;
  logic [WORD_W-1:0]     load_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      w3_q        <= '0;
      w1_q        <= '0;
      pixel_cnt_q <= '0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      w3_q        <= w3_d;
      w1_q        <= w1_d;
      pixel_cnt_q <= pixel_cnt_d;
      pix_q       <= pix_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    w3_d        = w3_q;
    w1_d        = w1_q;
    pixel_cnt_d = pixel_cnt_q;
    pix_d       = pix_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          w3_d        = words_3x3_i;
          w1_d        = words_1x1_i;
          pix_d       = layer_pixels_i;
          word_cnt_d  = '0;
          pixel_cnt_d = '0;
          state_d     = ST_RD_3X3;
        end
      end
      ST_RD_3X3: begin
        if (pop_3x3) begin
          if (word_cnt_q == w3_q) begin
            word_cnt_d = '0;
            state_d    = ST_RD_1X1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      ST_RD_1X1: begin
        if (pop_1x1) begin
          if (word_cnt_q == w1_q) begin
            word_cnt_d = '0;
            if (pixel_cnt_q == pix_q) begin
              state_d = ST_DRAIN;
            end else begin
              pixel_cnt_d = pixel_cnt_q + CNT_W'(1);
              state_d     = ST_RD_3X3;
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (hold_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the FIFO owned by the current state is looked at; the other one's empty flag is ignored.
  always_comb begin
    pop_3x3      = (state_q == ST_RD_3X3) & ~fifo_sq_3x3_empty_i & can_load;
    pop_1x1      = (state_q == ST_RD_1X1) & ~fifo_sq_1x1_empty_i & can_load;
    load_data    = pop_1x1 ? fifo_sq_1x1_rd_data_i : fifo_sq_3x3_rd_data_i;
    load_tag     = pop_1x1 & (word_cnt_q == w1_q);
    layer_done_o = (state_q == ST_DRAIN) & hold_empty;
    busy_o       = (state_q != ST_IDLE);
  end

  assign fifo_sq_3x3_rd_en_o = pop_3x3;
  assign fifo_sq_1x1_rd_en_o = pop_1x1;

  squeeze_beat_splitter #(
    .WORD_W(WORD_W),
    .BEAT_W(BEAT_W)
  ) u_splitter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (pop_3x3 | pop_1x1),
    .load_data_i (load_data),
    .load_tag_i  (load_tag),
    .beat_ready_i(beat_ready_i),
    .can_load_o  (can_load),
    .hold_empty_o(hold_empty),
    .beat_data_o (beat_data_o),
    .beat_valid_o(beat_valid_o),
    .pixel_last_o(pixel_last_o)
  );

endmodule
